// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Segment patterns are ordered a..g and are active-low.
package seg_disp_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} state_t;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;

  localparam logic [BIN_W-1:0] MAX_DISP = 14'd9999;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;

  localparam logic [0:6] SEG_TBL [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  function automatic logic [0:6] seg_of(input logic [BCD_W-1:0] d);
    return (d < 4'd10) ? SEG_TBL[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per clock, BIN_W steps.
// done flags the cycle whose edge performs the final step, so bcd is valid the cycle after.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int BIN_BITS = BIN_W
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [BIN_BITS-1:0]                   bin,
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_DIGITS-1:0][BCD_W-1:0]      bcd
);

  localparam int CNT_W = $clog2(BIN_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_BITS - 1);

  logic [BIN_BITS-1:0]              sh;
  logic [CNT_W-1:0]                 cnt;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] adj;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt + CNT_W'(1);
      if (cnt == LAST) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Binary-to-decimal 4-digit multiplexed display: load/convert/commit FSM plus a
// free-running digit scan with leading-zero blanking and overflow dashes.
module display_scan_ctrl
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             ready,
  output logic             overflow,
  output logic [0:6]       seg,
  output logic [3:0]       an,
  output logic             dp
);

  localparam int PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t                           state, state_nxt;
  logic                             start, cv_done, cv_busy, ovf_pend;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd, digits;
  logic [PS_W-1:0]                  presc;
  logic [1:0]                       idx;
  logic [NUM_DIGITS-1:0]            hi_zero;
  logic                             blank;
  logic [0:6]                       seg_nxt;
  logic [3:0]                       an_nxt;

  bin2bcd_seq #(.BIN_BITS(BIN_W)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin_in),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (bcd)
  );

  assign ready = (state == ST_IDLE) && !cv_busy;
  assign dp    = 1'b1;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE:   if (load && ready) begin
                   start     = 1'b1;
                   state_nxt = ST_CONV;
                 end
      ST_CONV:   if (cv_done) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Digits and overflow change together only in COMMIT, never mid-conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      digits   <= '0;
    end else begin
      state <= state_nxt;
      if (start) ovf_pend <= (bin_in > MAX_DISP);
      if (state == ST_COMMIT) begin
        digits   <= bcd;
        overflow <= ovf_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PS_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // hi_zero[k]: digit k and every digit above it are zero.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++)
      hi_zero[k] = ((digits >> (BCD_W * k)) == '0);
    blank   = BLANK_LZ && !overflow && (idx != 2'd0) && hi_zero[idx];
    seg_nxt = SEG_BLANK;
    an_nxt  = 4'hF;
    if (overflow) begin
      seg_nxt     = SEG_DASH;
      an_nxt[idx] = 1'b0;
    end else if (!blank) begin
      seg_nxt     = seg_of(digits[idx]);
      an_nxt[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (blanking on/off) share inputs and
// are compared each cycle against a decimal-arithmetic display model.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] bin_in = '0;

  logic       ready_a, ovf_a, dp_a, ready_b, ovf_b, dp_b;
  logic [0:6] seg_a, seg_b;
  logic [3:0] an_a, an_b;

  int vectors = 0;
  int errors  = 0;
  int cyc;

  logic [0:6] pat [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
    .ready(ready_a), .overflow(ovf_a), .seg(seg_a), .an(an_a), .dp(dp_a)
  );

  display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nlz (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
    .ready(ready_b), .overflow(ovf_b), .seg(seg_b), .an(an_b), .dp(dp_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan slot follows from this alone.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Expected {an, seg} for a shown value in a given slot.
  function automatic logic [10:0] model(input int val, input int slot, input bit blz);
    logic [3:0] a;
    logic [0:6] s;
    int hi;
    hi = val / (10 ** slot);
    a = 4'hF;
    a[slot] = 1'b0;
    if (val > 9999) s = 7'b1111110;
    else if (blz && slot != 0 && hi == 0) begin
      a = 4'hF;
      s = 7'b1111111;
    end else s = pat[hi % 10];
    return {a, s};
  endfunction

  task automatic do_load(input int v);
    @(negedge clk);
    bin_in = 14'(v);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Counts negedges until ready returns (bounded), then lets seg/an catch up.
  task automatic settle(output int n);
    n = 0;
    while (ready_a !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [10:0] ea, eb;
    int slot;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({an_a, seg_a, dp_a, ovf_a, ready_a} !== {4'hF, 7'h7F, 3'b101} ||
        {an_b, seg_b, dp_b, ovf_b, ready_b} !== {4'hF, 7'h7F, 3'b101}) begin
      errors++;
      $display("FAIL reset_state: an=%b seg=%b dp=%b ovf=%b rdy=%b, want 1111 1111111 1 0 1",
               an_a, seg_a, dp_a, ovf_a, ready_a);
    end
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      slot = ((cyc - 1) / 4) % 4;
      ea = model(0, slot, 1'b1);
      eb = model(0, slot, 1'b0);
      vectors++;
      if ({an_a, seg_a} !== ea || {an_b, seg_b} !== eb) begin
        errors++;
        $display("FAIL reset_release slot%0d: an=%b seg=%b / an=%b seg=%b, want %b / %b",
                 slot, an_a, seg_a, an_b, seg_b, ea, eb);
      end
    end
  endtask

  task automatic test_load_1234();
    logic [10:0] ea;
    int n, slot;
    do_load(1234);
    settle(n);
    vectors++;
    if (n != 15) begin
      errors++;
      $display("FAIL ready_low_1234: %0d cycles, want 15", n);
    end
    repeat (16) begin
      @(negedge clk);
      slot = ((cyc - 1) / 4) % 4;
      ea = model(1234, slot, 1'b1);
      vectors++;
      if ({an_a, seg_a, ovf_a} !== {ea, 1'b0}) begin
        errors++;
        $display("FAIL show_1234 slot%0d: an=%b seg=%b ovf=%b, want %b ovf=0",
                 slot, an_a, seg_a, ovf_a, ea);
      end
    end
  endtask

  task automatic test_boundaries();
    int vals [4] = '{9999, 0, 10000, 5};
    logic [10:0] ea, eb;
    logic eo;
    int n, slot;
    foreach (vals[i]) begin
      do_load(vals[i]);
      settle(n);
      vectors++;
      if (n != 15) begin
        errors++;
        $display("FAIL ready_low_%0d: %0d cycles, want 15", vals[i], n);
      end
      eo = (vals[i] > 9999);
      repeat (16) begin
        @(negedge clk);
        slot = ((cyc - 1) / 4) % 4;
        ea = model(vals[i], slot, 1'b1);
        eb = model(vals[i], slot, 1'b0);
        vectors++;
        if ({an_a, seg_a, ovf_a} !== {ea, eo} || {an_b, seg_b, ovf_b} !== {eb, eo}) begin
          errors++;
          $display("FAIL boundary_%0d slot%0d: an=%b seg=%b ovf=%b, want %b ovf=%b",
                   vals[i], slot, an_a, seg_a, ovf_a, ea, eo);
        end
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [10:0] ea;
    int n, slot;
    do_load(812);
    bin_in = 14'd55;
    load   = 1'b1;
    repeat (5) @(negedge clk);
    load   = 1'b0;
    settle(n);
    vectors++;
    if (n != 10) begin
      errors++;
      $display("FAIL ignore_ready_low: %0d more cycles, want 10", n);
    end
    repeat (16) begin
      @(negedge clk);
      slot = ((cyc - 1) / 4) % 4;
      ea = model(812, slot, 1'b1);
      vectors++;
      if ({an_a, seg_a} !== ea) begin
        errors++;
        $display("FAIL ignore_shows_812 slot%0d: an=%b seg=%b, want %b", slot, an_a, seg_a, ea);
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [10:0] ea;
    int slot;
    do_load(4321);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({an_a, seg_a, ready_a} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL midconv_reset: an=%b seg=%b rdy=%b, want 1111 1111111 1", an_a, seg_a, ready_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      slot = ((cyc - 1) / 4) % 4;
      ea = model(0, slot, 1'b1);
      vectors++;
      if ({an_a, seg_a, ovf_a, ready_a} !== {ea, 2'b01}) begin
        errors++;
        $display("FAIL midconv_after slot%0d: an=%b seg=%b ovf=%b rdy=%b, want %b 0 1",
                 slot, an_a, seg_a, ovf_a, ready_a, ea);
      end
    end
  endtask

  task automatic test_no_blank();
    logic [10:0] ea, eb;
    int n, slot;
    do_load(7);
    settle(n);
    repeat (16) begin
      @(negedge clk);
      slot = ((cyc - 1) / 4) % 4;
      ea = model(7, slot, 1'b1);
      eb = model(7, slot, 1'b0);
      vectors++;
      if ({an_b, seg_b} !== eb || {an_a, seg_a} !== ea) begin
        errors++;
        $display("FAIL no_blank_7 slot%0d: nlz an=%b seg=%b want %b, lz an=%b seg=%b want %b",
                 slot, an_b, seg_b, eb, an_a, seg_a, ea);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] ea, eb;
    logic eo;
    int v, n, slot;
    repeat (12) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                      : int'($urandom_range(0, 9999));
      do_load(v);
      settle(n);
      vectors++;
      if (n != 15) begin
        errors++;
        $display("FAIL rand_ready_low_%0d: %0d cycles, want 15", v, n);
      end
      eo = (v > 9999);
      repeat (16) begin
        @(negedge clk);
        slot = ((cyc - 1) / 4) % 4;
        ea = model(v, slot, 1'b1);
        eb = model(v, slot, 1'b0);
        vectors++;
        if ({an_a, seg_a, ovf_a} !== {ea, eo} || {an_b, seg_b, ovf_b} !== {eb, eo}) begin
          errors++;
          $display("FAIL rand_%0d slot%0d: an=%b seg=%b ovf=%b / an=%b seg=%b, want %b %b / %b",
                   v, slot, an_a, seg_a, ovf_a, an_b, seg_b, ea, eo, eb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_boundaries();
    test_ignore_busy();
    test_reset_mid_conv();
    test_no_blank();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
